block_dispatch: RTL and testbench



---
 rtl/block_dispatch.sv | 186 ++++++++++++++++++
 tb/tb_block_dispatch.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_dispatch.sv
// block_dispatch
// Kernel-launch sequencer for the per-MP block slots. It holds the kernel
// parameters in a local buffer and accepts a launch descriptor. For each grid
// block it allocates a free slot plus enough warps, then issues a bi burst
// that loads the slot descriptor and streams every kernel parameter into it.
//
// Ports:
//   clk, rst            clock; asynchronous reset, asserted low
//   hp_we/hp_wa/hp_di   host parameter buffer write (accepted in IDLE only)
//   launch_valid/ready  launch handshake; ready is high in IDLE
//   l_gdim, l_bdim      grid and block dimensions of the launch
//   l_num_warp          warps needed by each block
//   l_num_params        number of parameters to stream, 0..NUM_PARAMS
//   done_valid/done_bid a block slot has retired
//   bi, bid_init        block initialize strobe and target slot
//   num_warp, bdim,
//   gdim, bidx          descriptor loaded into the slot during bi
//   pwe/pwa/param       parameter stream, pwe only while bi
//   busy                sequencer is not idle
//   launch_done         one-cycle pulse after the last block has issued
module block_dispatch #(
  parameter int NUM_BLOCKS    = 4,
  parameter int BLOCKID_DEPTH = $clog2(NUM_BLOCKS),
  parameter int NUM_WARPS     = 16,
  parameter int WARPID_DEPTH  = $clog2(NUM_WARPS),
  parameter int BLOCK_DIM     = 32,
  parameter int GRID_DIM      = 32,
  parameter int R_DATA_WIDTH  = 32,
  parameter int NUM_PARAMS    = 8,
  parameter int PARAM_DEPTH   = $clog2(NUM_PARAMS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hp_we,
  input  logic [PARAM_DEPTH-1:0]   hp_wa,
  input  logic [R_DATA_WIDTH-1:0]  hp_di,
  input  logic                     launch_valid,
  output logic                     launch_ready,
  input  logic [GRID_DIM-1:0]      l_gdim,
  input  logic [BLOCK_DIM-1:0]     l_bdim,
  input  logic [WARPID_DEPTH-1:0]  l_num_warp,
  input  logic [PARAM_DEPTH:0]     l_num_params,
  input  logic                     done_valid,
  input  logic [BLOCKID_DEPTH-1:0] done_bid,
  output logic                     bi,
  output logic [BLOCKID_DEPTH-1:0] bid_init,
  output logic [WARPID_DEPTH-1:0]  num_warp,
  output logic [BLOCK_DIM-1:0]     bdim,
  output logic [GRID_DIM-1:0]      gdim,
  output logic [GRID_DIM-1:0]      bidx,
  output logic                     pwe,
  output logic [PARAM_DEPTH-1:0]   pwa,
  output logic [R_DATA_WIDTH-1:0]  param,
  output logic                     busy,
  output logic                     launch_done
);

  typedef enum logic [1:0] {IDLE, WAIT, INIT} state_t;

  state_t                    state;
  logic [R_DATA_WIDTH-1:0]   pbuf [NUM_PARAMS];
  logic [NUM_BLOCKS-1:0]     slot_busy;
  logic [WARPID_DEPTH-1:0]   slot_warps [NUM_BLOCKS];
  logic [WARPID_DEPTH:0]     free_warps;
  logic [PARAM_DEPTH:0]      num_params_q;
  logic [PARAM_DEPTH:0]      beat;

  logic                      slot_avail;
  logic [BLOCKID_DEPTH-1:0]  alloc_slot;
  logic                      alloc_ok;
  logic                      retire_ok;
  logic [WARPID_DEPTH:0]     alloc_amt;
  logic [WARPID_DEPTH:0]     retire_amt;
  logic [PARAM_DEPTH:0]      next_beat;
  logic                      last_beat;

  assign launch_ready = (state == IDLE);
  assign busy         = (state != IDLE);

  // Allocation looks only at registered slot state, so a slot retired in
  // this cycle becomes selectable in the next one. The downward scan leaves
  // the lowest-index free slot as the winner.
  always_comb begin
    slot_avail = 1'b0;
    alloc_slot = '0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        slot_avail = 1'b1;
        alloc_slot = BLOCKID_DEPTH'(i);
      end
    end
    alloc_ok   = (state == WAIT) && slot_avail && (free_warps >= {1'b0, num_warp});
    retire_ok  = done_valid && slot_busy[done_bid];
    alloc_amt  = alloc_ok  ? {1'b0, num_warp} : '0;
    retire_amt = retire_ok ? {1'b0, slot_warps[done_bid]} : '0;
    next_beat  = beat + (PARAM_DEPTH + 1)'(1);
    // A zero-parameter launch still gets one beat, hence >= rather than ==.
    last_beat  = (next_beat >= num_params_q);
  end

  // Host-loaded parameter buffer; frozen while a launch is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PARAMS; i++) pbuf[i] <= '0;
    end else if (hp_we && (state == IDLE)) begin
      pbuf[hp_wa] <= hp_di;
    end
  end

  // Launch FSM with registered outputs, together with the slot and warp
  // bookkeeping. An allocation and a retire in the same cycle always touch
  // different slots (only free slots allocate, only busy ones retire), so
  // both updates can land on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      bi           <= 1'b0;
      pwe          <= 1'b0;
      launch_done  <= 1'b0;
      bid_init     <= '0;
      num_warp     <= '0;
      bdim         <= '0;
      gdim         <= '0;
      bidx         <= '0;
      pwa          <= '0;
      param        <= '0;
      num_params_q <= '0;
      beat         <= '0;
      slot_busy    <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) slot_warps[i] <= '0;
      free_warps   <= (WARPID_DEPTH + 1)'(NUM_WARPS);
    end else begin
      launch_done <= 1'b0;
      free_warps  <= free_warps - alloc_amt + retire_amt;
      if (retire_ok) slot_busy[done_bid] <= 1'b0;

      case (state)
        IDLE: begin
          if (launch_valid) begin
            num_warp     <= l_num_warp;
            bdim         <= l_bdim;
            gdim         <= l_gdim;
            bidx         <= '0;
            num_params_q <= l_num_params;
            if (l_gdim == '0) launch_done <= 1'b1;
            else              state       <= WAIT;
          end
        end
        WAIT: begin
          if (alloc_ok) begin
            slot_busy[alloc_slot]  <= 1'b1;
            slot_warps[alloc_slot] <= num_warp;
            bid_init               <= alloc_slot;
            beat                   <= '0;
            pwa                    <= '0;
            param                  <= pbuf[0];
            pwe                    <= (num_params_q != '0);
            bi                     <= 1'b1;
            state                  <= INIT;
          end
        end
        INIT: begin
          if (last_beat) begin
            bi  <= 1'b0;
            pwe <= 1'b0;
            // Comparing at GRID_DIM width means bidx never has to wrap.
            if (bidx == gdim - GRID_DIM'(1)) begin
              launch_done <= 1'b1;
              state       <= IDLE;
            end else begin
              bidx  <= bidx + GRID_DIM'(1);
              state <= WAIT;
            end
          end else begin
            beat  <= next_beat;
            pwa   <= next_beat[PARAM_DEPTH-1:0];
            param <= pbuf[next_beat[PARAM_DEPTH-1:0]];
            pwe   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_dispatch.sv
// tb_block_dispatch
// Directed bench for block_dispatch. Expected bi beats are pushed to a
// scoreboard queue when a launch is driven and popped whenever the DUT
// shows bi. Launch timing, warp accounting and reset behaviour are checked
// at fixed points in the sequence.
module tb_block_dispatch;

  localparam int NB = 4;
  localparam int BD = 2;
  localparam int WD = 4;
  localparam int PD = 3;
  localparam int NP = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          hp_we;
  logic [PD-1:0] hp_wa;
  logic [31:0]   hp_di;
  logic          launch_valid;
  logic          launch_ready;
  logic [31:0]   l_gdim;
  logic [31:0]   l_bdim;
  logic [WD-1:0] l_num_warp;
  logic [PD:0]   l_num_params;
  logic          done_valid;
  logic [BD-1:0] done_bid;
  logic          bi;
  logic [BD-1:0] bid_init;
  logic [WD-1:0] num_warp;
  logic [31:0]   bdim;
  logic [31:0]   gdim;
  logic [31:0]   bidx;
  logic          pwe;
  logic [PD-1:0] pwa;
  logic [31:0]   param;
  logic          busy;
  logic          launch_done;

  always #5 clk = ~clk;

  block_dispatch dut (
    .clk(clk), .rst(rst),
    .hp_we(hp_we), .hp_wa(hp_wa), .hp_di(hp_di),
    .launch_valid(launch_valid), .launch_ready(launch_ready),
    .l_gdim(l_gdim), .l_bdim(l_bdim), .l_num_warp(l_num_warp),
    .l_num_params(l_num_params),
    .done_valid(done_valid), .done_bid(done_bid),
    .bi(bi), .bid_init(bid_init), .num_warp(num_warp), .bdim(bdim),
    .gdim(gdim), .bidx(bidx), .pwe(pwe), .pwa(pwa), .param(param),
    .busy(busy), .launch_done(launch_done)
  );

  typedef struct {
    logic [31:0] bid;
    logic [31:0] bidx;
    logic [31:0] pwa;
    logic [31:0] param;
    logic        pwe;
  } beat_t;

  beat_t       sb[$];
  logic [31:0] pmem [NP];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          bi_count = 0;
  int          done_count = 0;
  int          first_bi = -1;
  int          last_done = -1;
  int          launch_cyc = 0;
  int          d0;
  logic        ready_at_done = 1'b0;
  logic [31:0] exp_gdim, exp_bdim, exp_nwarp;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_beats(input int bid, input int blk, input int nbeats, input int np);
    beat_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.bid   = 32'(bid);
      b.bidx  = 32'(blk);
      b.pwa   = 32'(k);
      b.param = pmem[k];
      b.pwe   = (k < np);
      sb.push_back(b);
    end
  endtask

  task automatic expect_block(input int bid, input int blk, input int np);
    push_beats(bid, blk, (np == 0) ? 1 : np, np);
  endtask

  // One clock: advance past the edge, then monitor and score the outputs.
  task automatic step();
    beat_t b;
    @(posedge clk);
    #1;
    cyc++;
    if (bi === 1'b1) begin
      bi_count++;
      if (first_bi < 0) first_bi = cyc;
      if (sb.size() == 0) begin
        checkOutput("unexpected_bi", 32'(bi), 32'd0);
      end else begin
        b = sb.pop_front();
        checkOutput("bid_init", 32'(bid_init), b.bid);
        checkOutput("bidx", bidx, b.bidx);
        checkOutput("pwa", 32'(pwa), b.pwa);
        checkOutput("param", param, b.param);
        checkOutput("pwe", 32'(pwe), 32'(b.pwe));
        checkOutput("num_warp", 32'(num_warp), exp_nwarp);
        checkOutput("gdim", gdim, exp_gdim);
        checkOutput("bdim", bdim, exp_bdim);
      end
    end else if (pwe === 1'b1) begin
      checkOutput("pwe_without_bi", 32'(pwe), 32'd0);
    end
    if (launch_done === 1'b1) begin
      done_count++;
      last_done     = cyc;
      ready_at_done = launch_ready;
    end
  endtask

  task automatic applyStimulus(input int g, input int bd, input int nw, input int np);
    l_gdim       = 32'(g);
    l_bdim       = 32'(bd);
    l_num_warp   = WD'(nw);
    l_num_params = (PD + 1)'(np);
    exp_gdim     = 32'(g);
    exp_bdim     = 32'(bd);
    exp_nwarp    = 32'(nw);
    first_bi     = -1;
    bi_count     = 0;
    launch_valid = 1'b1;
    step();
    launch_valid = 1'b0;
    launch_cyc   = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    start = done_count;
    for (int i = 0; i < budget && done_count == start; i++) step();
    checkOutput({tag, "_done_seen"}, 32'(done_count - start), 32'd1);
  endtask

  task automatic write_param(input int a, input logic [31:0] d);
    hp_we = 1'b1;
    hp_wa = PD'(a);
    hp_di = d;
    step();
    hp_we   = 1'b0;
    pmem[a] = d;
  endtask

  task automatic retire(input int bid);
    done_valid = 1'b1;
    done_bid   = BD'(bid);
    step();
    done_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    hp_we = 1'b0; hp_wa = '0; hp_di = '0;
    launch_valid = 1'b0; l_gdim = '0; l_bdim = '0; l_num_warp = '0; l_num_params = '0;
    done_valid = 1'b0; done_bid = '0;
    exp_gdim = '0; exp_bdim = '0; exp_nwarp = '0;
    for (int i = 0; i < NP; i++) pmem[i] = '0;
    $display("[TB] start");

    // Reset values
    repeat (2) step();
    checkOutput("rst_bi", 32'(bi), 32'd0);
    checkOutput("rst_pwe", 32'(pwe), 32'd0);
    checkOutput("rst_launch_done", 32'(launch_done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_launch_ready", 32'(launch_ready), 32'd1);
    checkOutput("rst_bid_init", 32'(bid_init), 32'd0);
    checkOutput("rst_bidx", bidx, 32'd0);
    checkOutput("rst_param", param, 32'd0);
    checkOutput("rst_gdim", gdim, 32'd0);
    checkOutput("rst_free_warps", 32'(dut.free_warps), 32'd16);
    rst = 1'b1;
    step();

    // Full parameter burst, with a host write attempted while busy
    for (int i = 0; i < NP; i++) write_param(i, 32'hA0 + 32'(i));
    expect_block(0, 0, 8);
    applyStimulus(1, 32'h20, 4, 8);
    checkOutput("full_busy", 32'(busy), 32'd1);
    checkOutput("full_ready_low", 32'(launch_ready), 32'd0);
    hp_we = 1'b1; hp_wa = '0; hp_di = 32'hFF;
    step();
    hp_we = 1'b0;
    wait_done("full", 20);
    checkOutput("full_first_bi", 32'(first_bi - launch_cyc), 32'd1);
    checkOutput("full_bi_cycles", 32'(bi_count), 32'd8);
    checkOutput("full_done_cycle", 32'(last_done - launch_cyc), 32'd9);
    checkOutput("full_ready_at_done", 32'(ready_at_done), 32'd1);
    checkOutput("full_free_warps", 32'(dut.free_warps), 32'd12);
    checkOutput("full_sb_drained", 32'(sb.size()), 32'd0);
    retire(0);
    checkOutput("full_retired_free", 32'(dut.free_warps), 32'd16);

    // Warp starvation: four blocks fill every slot, the fifth waits for slot 2
    for (int i = 0; i < 4; i++) expect_block(i, i, 1);
    expect_block(2, 4, 1);
    applyStimulus(5, 32'h10, 4, 1);
    repeat (16) step();
    checkOutput("starve_issued", 32'(bi_count), 32'd4);
    checkOutput("starve_busy", 32'(busy), 32'd1);
    checkOutput("starve_pending", 32'(sb.size()), 32'd1);
    checkOutput("starve_free", 32'(dut.free_warps), 32'd0);
    retire(2);
    wait_done("starve", 10);
    checkOutput("starve_total", 32'(bi_count), 32'd5);
    checkOutput("starve_sb_drained", 32'(sb.size()), 32'd0);
    checkOutput("starve_free_after", 32'(dut.free_warps), 32'd0);
    for (int i = 0; i < 4; i++) retire(i);
    checkOutput("starve_retired_free", 32'(dut.free_warps), 32'd16);

    // Zero parameters: two single-beat blocks with pwe low
    expect_block(0, 0, 0);
    expect_block(1, 1, 0);
    applyStimulus(2, 32'h8, 2, 0);
    wait_done("zero", 10);
    checkOutput("zero_bi_cycles", 32'(bi_count), 32'd2);
    checkOutput("zero_first_bi", 32'(first_bi - launch_cyc), 32'd1);
    checkOutput("zero_done_cycle", 32'(last_done - launch_cyc), 32'd4);
    checkOutput("zero_sb_drained", 32'(sb.size()), 32'd0);
    retire(0);
    retire(1);

    // Empty grid
    d0 = done_count;
    applyStimulus(0, 32'h8, 2, 3);
    checkOutput("empty_done_now", 32'(done_count - d0), 32'd1);
    checkOutput("empty_busy", 32'(busy), 32'd0);
    checkOutput("empty_ready", 32'(launch_ready), 32'd1);
    repeat (3) step();
    checkOutput("empty_no_bi", 32'(bi_count), 32'd0);
    checkOutput("empty_single_pulse", 32'(done_count - d0), 32'd1);

    // Retire during allocation, then a retire of an idle slot
    expect_block(0, 0, 1);
    expect_block(1, 1, 1);
    expect_block(2, 2, 1);
    applyStimulus(3, 32'h4, 2, 1);
    wait_done("fill", 15);
    checkOutput("fill_free", 32'(dut.free_warps), 32'd10);
    expect_block(3, 0, 1);
    d0 = done_count;
    applyStimulus(1, 32'h4, 3, 1);
    retire(1);
    checkOutput("overlap_free", 32'(dut.free_warps), 32'd9);
    checkOutput("overlap_slots", 32'(dut.slot_busy), 32'h0000000D);
    retire(1);
    checkOutput("idle_retire_free", 32'(dut.free_warps), 32'd9);
    checkOutput("overlap_done", 32'(done_count - d0), 32'd1);
    checkOutput("overlap_sb_drained", 32'(sb.size()), 32'd0);
    retire(0);
    retire(2);
    retire(3);
    checkOutput("overlap_retired_free", 32'(dut.free_warps), 32'd16);

    // Reset in the middle of the third parameter beat
    push_beats(0, 0, 3, 8);
    applyStimulus(1, 32'h40, 4, 8);
    repeat (3) step();
    checkOutput("midrst_bi_before", 32'(bi), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("midrst_bi", 32'(bi), 32'd0);
    checkOutput("midrst_pwe", 32'(pwe), 32'd0);
    checkOutput("midrst_ready", 32'(launch_ready), 32'd1);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_free", 32'(dut.free_warps), 32'd16);
    checkOutput("midrst_slots", 32'(dut.slot_busy), 32'd0);
    checkOutput("midrst_sb_drained", 32'(sb.size()), 32'd0);
    for (int i = 0; i < NP; i++) pmem[i] = '0;
    #2;
    rst = 1'b1;
    step();
    expect_block(0, 0, 8);
    applyStimulus(1, 32'h40, 1, 8);
    wait_done("post_reset", 20);
    checkOutput("post_reset_bi_cycles", 32'(bi_count), 32'd8);
    checkOutput("post_reset_sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
